// File: rtl/servant_mem_arb.sv
// Two-master Wishbone arbiter in front of the single servant RAM port:
// round-robin between the SERV bus (m0) and SPI bridge (m1), bounded m1 lock, ack watchdog.
module servant_mem_arb #(
    parameter int aw       = 13,
    parameter int lock_max = 16,
    parameter int timeout  = 64
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic [aw-1:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    input  logic          i_m1_lock,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [31:0]   o_rdt,
    output logic [aw-1:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [9:0] TO_LAST  = 10'(timeout - 1);
    localparam logic [7:0] LOCK_MAX = 8'(lock_max);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       locked_q, locked_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [9:0] to_cnt_q, to_cnt_d;
    logic       timeout_q, timeout_d;
    logic       pick1;
    logic       to_hit;
    logic [1:0] gnt;
    logic [1:0] ack_vec;
    logic [1:0] err_vec;

    assign gnt    = {state_q == GNT1, state_q == GNT0};
    // A real ack in the last watchdog cycle takes precedence over the forced one.
    assign to_hit = (state_q != IDLE) && !i_s_ack && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
        pick1      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    if (lock_cnt_q == LOCK_MAX) begin
                        pick1 = 1'b0;
                    end else if (locked_q) begin
                        pick1 = 1'b1;
                    end else begin
                        pick1 = !last_q;
                    end
                end else begin
                    pick1 = i_m1_cyc;
                end
                if (i_m0_cyc || i_m1_cyc) begin
                    last_d   = pick1;
                    to_cnt_d = '0;
                    if (pick1) begin
                        state_d = GNT1;
                        // The grant that opens a burst counts too, so m0 sits out at most lock_max m1 grants.
                        if (i_m0_cyc && (lock_cnt_q != LOCK_MAX)) begin
                            lock_cnt_d = lock_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d    = GNT0;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                    end
                end
            end
            GNT0, GNT1: begin
                if (i_s_ack) begin
                    state_d = IDLE;
                    if (state_q == GNT1) begin
                        locked_d = i_m1_lock;
                        if (!i_m1_lock) begin
                            lock_cnt_d = '0;
                        end
                    end
                end else if (to_hit) begin
                    state_d    = IDLE;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Responses are suppressed while reset is high so an in-flight ack never escapes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi] = gnt[gi] && (i_s_ack || to_hit) && !wb_rst;
            assign err_vec[gi] = gnt[gi] && to_hit && !wb_rst;
        end
    endgenerate

    assign o_m0_ack  = ack_vec[0];
    assign o_m1_ack  = ack_vec[1];
    assign o_m0_err  = err_vec[0];
    assign o_m1_err  = err_vec[1];
    assign o_s_cyc   = |gnt;
    assign o_rdt     = i_s_rdt;
    assign o_timeout = timeout_q;

    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        if (gnt[0]) begin
            o_s_adr = i_m0_adr;
            o_s_dat = i_m0_dat;
            o_s_sel = i_m0_sel;
            o_s_we  = i_m0_we;
        end else if (gnt[1]) begin
            o_s_adr = i_m1_adr;
            o_s_dat = i_m1_dat;
            o_s_sel = i_m1_sel;
            o_s_we  = i_m1_we;
        end
    end

endmodule

// File: tb/tb_servant_mem_arb.sv
// Directed bench for servant_mem_arb against a small RAM model with selectable ack behaviour.
module tb_servant_mem_arb;

    localparam int AW = 13;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic [AW-1:0] i_m0_adr, i_m1_adr;
    logic [31:0]   i_m0_dat, i_m1_dat;
    logic [3:0]    i_m0_sel, i_m1_sel;
    logic          i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc, i_m1_lock;
    logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [31:0]   o_rdt;
    logic [AW-1:0] o_s_adr;
    logic [31:0]   o_s_dat;
    logic [3:0]    o_s_sel;
    logic          o_s_we, o_s_cyc;
    logic [31:0]   i_s_rdt;
    logic          i_s_ack;
    logic          o_timeout;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk = ~wb_clk;

    servant_mem_arb #(.aw(AW), .lock_max(16), .timeout(64)) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .i_m0_adr (i_m0_adr),
        .i_m0_dat (i_m0_dat),
        .i_m0_sel (i_m0_sel),
        .i_m0_we  (i_m0_we),
        .i_m0_cyc (i_m0_cyc),
        .o_m0_ack (o_m0_ack),
        .o_m0_err (o_m0_err),
        .i_m1_adr (i_m1_adr),
        .i_m1_dat (i_m1_dat),
        .i_m1_sel (i_m1_sel),
        .i_m1_we  (i_m1_we),
        .i_m1_cyc (i_m1_cyc),
        .i_m1_lock(i_m1_lock),
        .o_m1_ack (o_m1_ack),
        .o_m1_err (o_m1_err),
        .o_rdt    (o_rdt),
        .o_s_adr  (o_s_adr),
        .o_s_dat  (o_s_dat),
        .o_s_sel  (o_s_sel),
        .o_s_we   (o_s_we),
        .o_s_cyc  (o_s_cyc),
        .i_s_rdt  (i_s_rdt),
        .i_s_ack  (i_s_ack),
        .o_timeout(o_timeout)
    );

    // RAM model: mode 0 acks one cycle after cyc, 1 never acks, 2 acks on the 64th cyc cycle.
    int          ram_mode = 0;
    int          cyc_run  = 0;
    logic        ram_ack  = 1'b0;
    logic [31:0] ram_rdt  = 32'h0;

    assign i_s_ack = ram_ack;
    assign i_s_rdt = ram_rdt;

    always @(posedge wb_clk) begin
        ram_ack <= ((ram_mode == 0) && o_s_cyc && !ram_ack) ||
                   ((ram_mode == 2) && o_s_cyc && (cyc_run == 62));
        cyc_run <= o_s_cyc ? cyc_run + 1 : 0;
        ram_rdt <= (o_s_adr == 13'h010) ? 32'hDEADBEEF : ({19'b0, o_s_adr} ^ 32'h5A5A0000);
    end

    int order_q[$];
    int exp_q[$];
    int max_wait0, min_gap, max_gap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic reset_dut();
        wb_rst    = 1'b1;
        i_m0_cyc  = 1'b0;
        i_m1_cyc  = 1'b0;
        i_m1_lock = 1'b0;
        i_m0_adr  = '0;
        i_m1_adr  = '0;
        i_m0_dat  = '0;
        i_m1_dat  = '0;
        i_m0_sel  = '0;
        i_m1_sel  = '0;
        i_m0_we   = 1'b0;
        i_m1_we   = 1'b0;
        ram_mode  = 0;
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
    endtask

    // Both masters re-request immediately after every ack until their counts run out.
    task automatic run_pair(input int n0, input int n1, input logic lock1, input int budget);
        int   rem0, rem1, req0_t, gap, cnt, w;
        logic seen;
        rem0 = n0; rem1 = n1; req0_t = 0; gap = 0; cnt = 0; seen = 1'b0;
        order_q.delete();
        max_wait0 = 0; min_gap = 1000; max_gap = 0;
        i_m0_adr = 13'h100; i_m0_we = 1'b0; i_m0_sel = 4'hF; i_m0_dat = 32'h0;
        i_m1_adr = 13'h200; i_m1_we = 1'b1; i_m1_sel = 4'hF; i_m1_dat = 32'h10000000;
        i_m1_lock = lock1;
        i_m0_cyc  = (rem0 > 0);
        i_m1_cyc  = (rem1 > 0);
        while ((rem0 > 0 || rem1 > 0) && cnt < budget) begin
            @(negedge wb_clk);
            cnt++;
            if (o_s_cyc) begin
                if (seen && gap > 0) begin
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                gap  = 0;
                seen = 1'b1;
            end else if (seen) begin
                gap++;
            end
            if (o_m0_ack) begin
                order_q.push_back(0);
                w = cnt - req0_t + 1;
                if (w > max_wait0) max_wait0 = w;
                rem0--;
                req0_t   = cnt + 1;
                i_m0_adr = i_m0_adr + 13'd1;
                if (rem0 == 0) i_m0_cyc = 1'b0;
            end
            if (o_m1_ack) begin
                order_q.push_back(1);
                rem1--;
                i_m1_adr = i_m1_adr + 13'd1;
                i_m1_dat = i_m1_dat + 32'd1;
                if (rem1 == 0) i_m1_cyc = 1'b0;
            end
        end
        chk("pair_budget_left", 32'(rem0 + rem1), 0);
        i_m0_cyc  = 1'b0;
        i_m1_cyc  = 1'b0;
        i_m1_lock = 1'b0;
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_len"}, 32'(order_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < order_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_%0d", tag, i), 32'(order_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int m1_acks;
        int hit;
        int early;

        // Reset state and single m0 read
        reset_dut();
        chk("rst_s_cyc", 32'(o_s_cyc), 0);
        chk("rst_m0_ack", 32'(o_m0_ack), 0);
        chk("rst_m1_ack", 32'(o_m1_ack), 0);
        chk("rst_errs", 32'({o_m0_err, o_m1_err}), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        chk("rst_s_adr", 32'(o_s_adr), 0);
        i_m0_cyc = 1'b1; i_m0_adr = 13'h010; i_m0_we = 1'b0; i_m0_sel = 4'hF;
        m1_acks = 0;
        @(negedge wb_clk);
        chk("t1_s_cyc_c1", 32'(o_s_cyc), 1);
        chk("t1_s_adr", 32'(o_s_adr), 32'h010);
        chk("t1_s_we", 32'(o_s_we), 0);
        chk("t1_ack_c1", 32'(o_m0_ack), 0);
        m1_acks += int'(o_m1_ack);
        @(negedge wb_clk);
        chk("t1_ack_c2", 32'(o_m0_ack), 1);
        chk("t1_err", 32'(o_m0_err), 0);
        chk("t1_rdt", o_rdt, 32'hDEADBEEF);
        m1_acks += int'(o_m1_ack);
        i_m0_cyc = 1'b0;
        @(negedge wb_clk);
        chk("t1_bubble", 32'(o_s_cyc), 0);
        chk("t1_idle_adr", 32'(o_s_adr), 0);
        m1_acks += int'(o_m1_ack);
        chk("t1_m1_ack_never", 32'(m1_acks), 0);

        // Round-robin alternation, m0 wins the first tie
        reset_dut();
        run_pair(4, 4, 1'b0, 100);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 2);
        chk_order("t2_order");
        chk("t2_min_gap", 32'(min_gap), 1);
        chk("t2_max_gap", 32'(max_gap), 1);

        // Locked m1 burst of 40 against a continuously requesting m0
        reset_dut();
        run_pair(4, 40, 1'b1, 400);
        exp_q.delete();
        exp_q.push_back(0);
        for (int i = 0; i < 16; i++) exp_q.push_back(1);
        exp_q.push_back(0);
        for (int i = 0; i < 16; i++) exp_q.push_back(1);
        exp_q.push_back(0);
        for (int i = 0; i < 8; i++) exp_q.push_back(1);
        exp_q.push_back(0);
        chk_order("t3_order");
        chk("t3_m0_wait_max", 32'(max_wait0), 51);
        chk("t3_max_gap", 32'(max_gap), 1);

        // Watchdog: RAM never acks an m1 write
        reset_dut();
        ram_mode = 1;
        i_m1_cyc = 1'b1; i_m1_we = 1'b1; i_m1_adr = 13'h055;
        i_m1_dat = 32'hA5A50001; i_m1_sel = 4'h6;
        hit = -1; early = 0;
        for (int c = 1; c <= 200 && hit < 0; c++) begin
            @(negedge wb_clk);
            if (c == 1) begin
                chk("t4_s_adr", 32'(o_s_adr), 32'h055);
                chk("t4_s_dat", o_s_dat, 32'hA5A50001);
                chk("t4_s_sel", 32'(o_s_sel), 32'h6);
                chk("t4_s_we", 32'(o_s_we), 1);
                i_m0_cyc = 1'b1; i_m0_adr = 13'h077; i_m0_we = 1'b0; i_m0_sel = 4'hF;
            end
            if (o_m1_ack) begin
                hit = c;
                chk("t4_m1_err", 32'(o_m1_err), 1);
                ram_mode = 0;
                i_m1_cyc = 1'b0;
            end else begin
                early += int'(o_timeout) + int'(o_m0_ack);
            end
        end
        chk("t4_ack_cycle", 32'(hit), 64);
        chk("t4_no_early_events", 32'(early), 0);
        @(negedge wb_clk);
        chk("t4_timeout_sticky", 32'(o_timeout), 1);
        chk("t4_bubble", 32'(o_s_cyc), 0);
        @(negedge wb_clk);
        chk("t4_m0_gnt", 32'(o_s_cyc), 1);
        chk("t4_m0_adr", 32'(o_s_adr), 32'h077);
        @(negedge wb_clk);
        chk("t4_m0_ack", 32'(o_m0_ack), 1);
        chk("t4_m0_err", 32'(o_m0_err), 0);
        i_m0_cyc = 1'b0;
        @(negedge wb_clk);
        chk("t4_timeout_held", 32'(o_timeout), 1);

        // Ack landing on the last watchdog cycle wins
        reset_dut();
        ram_mode = 2;
        i_m0_cyc = 1'b1; i_m0_adr = 13'h010; i_m0_we = 1'b0; i_m0_sel = 4'hF;
        hit = -1;
        for (int c = 1; c <= 200 && hit < 0; c++) begin
            @(negedge wb_clk);
            if (o_m0_ack) begin
                hit = c;
                chk("t5_err", 32'(o_m0_err), 0);
                chk("t5_rdt", o_rdt, 32'hDEADBEEF);
                i_m0_cyc = 1'b0;
                ram_mode = 0;
            end
        end
        chk("t5_ack_cycle", 32'(hit), 64);
        @(negedge wb_clk);
        chk("t5_timeout", 32'(o_timeout), 0);

        // Reset while m1 is granted
        reset_dut();
        i_m1_cyc = 1'b1; i_m1_adr = 13'h0AA; i_m1_we = 1'b1; i_m1_sel = 4'hF;
        @(negedge wb_clk);
        chk("t6_gnt1", 32'(o_s_cyc), 1);
        @(posedge wb_clk);
        #1 wb_rst = 1'b1;
        @(negedge wb_clk);
        chk("t6_no_ack", 32'(o_m1_ack), 0);
        i_m1_cyc = 1'b0;
        @(negedge wb_clk);
        chk("t6_s_cyc", 32'(o_s_cyc), 0);
        chk("t6_timeout", 32'(o_timeout), 0);
        wb_rst = 1'b0;
        run_pair(1, 1, 1'b0, 50);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(1);
        chk_order("t6_order");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
